// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM states,
// requester ids and default port widths.
package riscv_mem_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  function automatic logic other_master(input logic g);
    return ~g;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way combinational winner select. DMEM_ARB_RR_EN selects round-robin
// tie-breaking against last_grant; otherwise m0 has fixed priority.
module rr_pick2
  import riscv_mem_pkg::*;
(
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last_grant,
  output logic o_gnt
);

`ifdef DMEM_ARB_RR_EN
  always_comb begin
    o_gnt = M0;
    if (i_req0 && i_req1) begin
      o_gnt = other_master(i_last_grant);
    end else if (i_req1) begin
      o_gnt = M1;
    end else begin
      o_gnt = M0;
    end
  end
`else
  // History only matters for round-robin; fixed priority ignores it.
  logic w_unused_last_grant;
  assign w_unused_last_grant = i_last_grant;

  always_comb begin
    o_gnt = M0;
    if (i_req0) begin
      o_gnt = M0;
    end else if (i_req1) begin
      o_gnt = M1;
    end else begin
      o_gnt = M0;
    end
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between m0 (CPU) and m1 (DMA/loader) with an
// IDLE/ACCESS/RESP FSM. Tie-break policy set by DMEM_ARB_RR_EN (see rr_pick2).
module dmem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ready,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] DataAdr,
  output logic [DATA_W-1:0] WriteData,
  output logic              MemWrite,
  input  logic [DATA_W-1:0] ReadData
);

  arb_state_t        r_state;
  logic              r_gnt;
  logic              r_last_grant;
  logic              r_m0_ready;
  logic              r_m1_ready;
  logic [DATA_W-1:0] r_m0_rdata;
  logic [DATA_W-1:0] r_m1_rdata;
  logic              w_winner;

  rr_pick2 u_pick (
    .i_req0       (m0_req),
    .i_req1       (m1_req),
    .i_last_grant (r_last_grant),
    .o_gnt        (w_winner)
  );

  // Memory port follows the granted requester live, but only during ACCESS.
  always_comb begin
    DataAdr   = '0;
    WriteData = '0;
    MemWrite  = 1'b0;
    if (r_state == ACCESS) begin
      if (r_gnt == M1) begin
        DataAdr   = m1_addr;
        WriteData = m1_wdata;
        MemWrite  = m1_we;
      end else begin
        DataAdr   = m0_addr;
        WriteData = m0_wdata;
        MemWrite  = m0_we;
      end
    end else begin
      DataAdr   = '0;
      WriteData = '0;
      MemWrite  = 1'b0;
    end
  end

  // last_grant resets to m1 so the first round-robin tie goes to m0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_gnt        <= M0;
      r_last_grant <= M1;
      r_m0_ready   <= 1'b0;
      r_m1_ready   <= 1'b0;
      r_m0_rdata   <= '0;
      r_m1_rdata   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_m0_ready <= 1'b0;
          r_m1_ready <= 1'b0;
          if (m0_req || m1_req) begin
            r_gnt   <= w_winner;
            r_state <= ACCESS;
          end
        end
        ACCESS: begin
          if (r_gnt == M1) begin
            r_m1_ready <= 1'b1;
            if (!m1_we) begin
              r_m1_rdata <= ReadData;
            end
          end else begin
            r_m0_ready <= 1'b1;
            if (!m0_we) begin
              r_m0_rdata <= ReadData;
            end
          end
          r_last_grant <= r_gnt;
          r_state      <= RESP;
        end
        RESP: begin
          r_m0_ready <= 1'b0;
          r_m1_ready <= 1'b0;
          r_state    <= IDLE;
        end
        default: begin
          r_m0_ready <= 1'b0;
          r_m1_ready <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  assign m0_ready = r_m0_ready;
  assign m1_ready = r_m1_ready;
  assign m0_rdata = r_m0_rdata;
  assign m1_rdata = r_m1_rdata;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data memory port between two requesters: m0 (CPU load/store path) and m1 (DMA/program loader).
- Sits between the requesters and the data memory in the top-level SoC.
- Uses a small FSM that registers the grant, runs one memory access, then returns a registered response with a one-cycle ready pulse.
- Memory contract: combinational read; write commits on clk rising edge when MemWrite=1.

Parameters:
- ADDR_W, 32, address width of requester and memory ports.
- DATA_W, 32, data width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- m0_req  in  1  m0 request; held high with address/data stable until m0_ready.
- m0_we  in  1  m0 write enable (1=store, 0=load).
- m0_addr  in  ADDR_W  m0 address.
- m0_wdata  in  DATA_W  m0 write data.
- m0_ready  out  1  one-cycle completion pulse.
- m0_rdata  out  DATA_W  load data, valid while m0_ready=1.
- m1_req, m1_we, m1_addr, m1_wdata, m1_ready, m1_rdata: same as m0 for requester 1.
- DataAdr  out  ADDR_W  memory address.
- WriteData  out  DATA_W  memory write data.
- MemWrite  out  1  memory write strobe.
- ReadData  in  DATA_W  memory read data (combinational).

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, last_grant=1 (so m0 wins first under round-robin).
  - m*_ready=0, m*_rdata=0, MemWrite=0, DataAdr=0, WriteData=0.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - No req: stay in IDLE.
  - Any req: choose a winner, latch it in gnt, go to ACCESS.
  - Memory outputs are 0 and MemWrite=0 in IDLE.
- ACCESS (exactly 1 cycle):
  - DataAdr and WriteData are driven combinationally from the gnt requester.
  - MemWrite = gnt requester's we.
  - At the clock edge: a write commits in memory; for a load, ReadData is captured into the gnt requester's rdata register.
  - Next state RESP; last_grant <= gnt.
- RESP (exactly 1 cycle):
  - gnt requester's ready=1. Its rdata holds the captured value; for a store it holds the previous value.
  - MemWrite=0. Next state IDLE.
- Latency: request sampled in IDLE at cycle N; memory access at N+1; ready at N+2. Minimum spacing for back-to-back transactions is 3 cycles.
- Requester rule: deassert req, or present a new transaction, on the edge after ready. A req still high in IDLE is treated as a new request.
- Simultaneous requests: arbitration per the Optional Feature. The loser keeps req high and is served on the next IDLE.
- Request changes:
  - Losing req dropped before grant: ignored, no access.
  - Granted requester changes addr/we or drops req during ACCESS: protocol violation. The memory sees the current inputs; no checking is performed.
- Reset mid-transaction: the FSM returns to IDLE immediately. A write in ACCESS whose edge did not occur is not committed, and no ready is issued.
- The non-granted requester's ready is always 0.

Optional Feature:
- Macro: DMEM_ARB_RR_EN.
- Defined: round-robin. On a tie, the requester other than last_grant wins; with a single requester, it wins.
- Undefined: fixed priority, m0 always wins a tie. last_grant is still maintained but does not affect arbitration.

Decomposition:
- Shared package riscv_mem_pkg:
  - arb_state_t enum (IDLE, ACCESS, RESP).
  - Constants M0=1'b0 and M1=1'b1.
  - Default width constants ADDR_W/DATA_W.
- One natural sub-module: rr_pick2. It is a combinational winner select from (req0, req1, last_grant) and contains the DMEM_ARB_RR_EN choice. The FSM, muxes and rdata registers stay in dmem_arbiter.

Test Plan:
- Reset: hold reset=0 for 3 cycles with both reqs high -> all readies 0, MemWrite=0, DataAdr=0. Release reset -> m0 is served first: ACCESS 1 cycle after release, ready 2 cycles after release.
- Single write then read by m0: store 0xDEADBEEF to 0x10 -> MemWrite=1 for exactly 1 cycle with DataAdr=0x10, m0_ready 2 cycles after req. Load 0x10 -> m0_rdata=0xDEADBEEF while m0_ready=1.
- Contention: m0 and m1 both request continuously.
  - DMEM_ARB_RR_EN defined: grants alternate m0, m1, m0, m1, one completion every 3 cycles.
  - DMEM_ARB_RR_EN undefined: only m0 is served while its req stays high.
- m1 loader writes 0x00000001..0x00000004 to 0x0..0xC, then m0 reads them back -> rdata matches each value; m1_ready never coincides with m0_ready.
- Reset asserted during ACCESS of an m1 store of 0x55 to 0x20 -> memory at 0x20 unchanged; m1_ready never pulses; FSM in IDLE after reset release.
